wb_arbiter: RTL and testbench

- Round-robin Wishbone arbiter that shares the single system slave bus among NM masters: the CPU bus interface, DMA and the video fetch engine.
- Grant is held for the duration of the winner's cyc, so single-beat cycles and held-cyc sequences are never split.
- A per-transfer watchdog terminates any strobe the slave side never acks, returning an all-ones read word and a sticky error flag with the faulting address.

---
 rtl/wb_arbiter.sv | 153 +++++++++++++++
 tb/tb_wb_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: NM masters share one slave bus, grant held for
// the winner's whole cyc, with a per-transfer watchdog that fakes an ack on a hung slave.
module wb_arbiter #(
  parameter int NM    = 3,
  parameter int TMO_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NM-1:0]      m_cyc_i,
  input  logic [NM-1:0]      m_stb_i,
  input  logic [NM-1:0]      m_we_i,
  input  logic [4*NM-1:0]    m_sel_i,
  input  logic [30*NM-1:0]   m_adr_i,
  input  logic [32*NM-1:0]   m_dat_i,
  output logic [NM-1:0]      m_ack_o,
  output logic [31:0]        m_dat_o,
  output logic               s_cyc_o,
  output logic               s_stb_o,
  output logic               s_we_o,
  output logic [3:0]         s_sel_o,
  output logic [29:0]        s_adr_o,
  output logic [31:0]        s_dat_o,
  input  logic               s_ack_i,
  input  logic [31:0]        s_dat_i,
  input  logic               tmo_clr_i,
  output logic               tmo_o,
  output logic [29:0]        tmo_adr_o
);

  localparam int GW = $clog2(NM);
  // Count value held during the last unacked cycle before the watchdog fires.
  localparam logic [TMO_W-1:0] CNT_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, BUSY, TMO} state_t;

  state_t            state_reg, state_next;
  logic [GW-1:0]     grant_reg, grant_next;
  logic [GW-1:0]     last_reg, last_next;
  logic [TMO_W-1:0]  cnt_reg, cnt_next;
  logic              tmo_reg, tmo_next;
  logic [29:0]       tmo_adr_reg, tmo_adr_next;

  logic [GW-1:0]     arb_idx;
  logic [GW-1:0]     cand;
  logic              arb_found;

  logic [3:0]        sel_arr [NM];
  logic [29:0]       adr_arr [NM];
  logic [31:0]       dat_arr [NM];

  genvar gi;
  generate
    for (gi = 0; gi < NM; gi++) begin : g_split
      assign sel_arr[gi] = m_sel_i[4*gi +: 4];
      assign adr_arr[gi] = m_adr_i[30*gi +: 30];
      assign dat_arr[gi] = m_dat_i[32*gi +: 32];
    end
  endgenerate

  // First requester after the previous owner, wrapping modulo NM.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = last_reg;
    cand      = '0;
    for (int i = 1; i <= NM; i++) begin
      cand = GW'((int'(last_reg) + i) % NM);
      if (!arb_found && m_cyc_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    last_next    = last_reg;
    cnt_next     = '0;
    tmo_next     = tmo_reg & ~tmo_clr_i;
    tmo_adr_next = tmo_adr_reg;
    s_cyc_o      = 1'b0;
    s_stb_o      = 1'b0;
    s_we_o       = 1'b0;
    s_sel_o      = '0;
    s_adr_o      = '0;
    s_dat_o      = '0;
    m_ack_o      = '0;
    m_dat_o      = '0;

    case (state_reg)
      IDLE: begin
        if (arb_found) begin
          state_next = BUSY;
          grant_next = arb_idx;
        end
      end

      BUSY: begin
        s_cyc_o            = m_cyc_i[grant_reg];
        s_stb_o            = m_stb_i[grant_reg];
        s_we_o             = m_we_i[grant_reg];
        s_sel_o            = sel_arr[grant_reg];
        s_adr_o            = adr_arr[grant_reg];
        s_dat_o            = dat_arr[grant_reg];
        m_ack_o[grant_reg] = s_ack_i & m_stb_i[grant_reg];
        m_dat_o            = s_dat_i;
        if (!m_cyc_i[grant_reg]) begin
          state_next = IDLE;
          last_next  = grant_reg;
        end else if (m_stb_i[grant_reg] && !s_ack_i) begin
          // A late ack in the final cycle still wins because it skips this branch.
          if (cnt_reg == CNT_LAST) begin
            state_next   = TMO;
            tmo_next     = 1'b1;
            tmo_adr_next = adr_arr[grant_reg];
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      TMO: begin
        m_ack_o[grant_reg] = 1'b1;
        m_dat_o            = '1;
        state_next         = BUSY;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      grant_reg   <= '0;
      last_reg    <= GW'(NM - 1);
      cnt_reg     <= '0;
      tmo_reg     <= 1'b0;
      tmo_adr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      last_reg    <= last_next;
      cnt_reg     <= cnt_next;
      tmo_reg     <= tmo_next;
      tmo_adr_reg <= tmo_adr_next;
    end
  end

  assign tmo_o     = tmo_reg;
  assign tmo_adr_o = tmo_adr_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: arbitration order, held-cyc bursts, watchdog
// boundaries, sticky flag priority and asynchronous reset.
module tb_wb_arbiter;
  localparam int NM = 3;

  logic            clk;
  logic            rst;
  logic [NM-1:0]   m_cyc_i, m_stb_i, m_we_i;
  logic [4*NM-1:0] m_sel_i;
  logic [30*NM-1:0] m_adr_i;
  logic [32*NM-1:0] m_dat_i;
  logic [NM-1:0]   m_ack_o;
  logic [31:0]     m_dat_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]      s_sel_o;
  logic [29:0]     s_adr_o;
  logic [31:0]     s_dat_o;
  logic            s_ack_i;
  logic [31:0]     s_dat_i;
  logic            tmo_clr_i;
  logic            tmo_o;
  logic [29:0]     tmo_adr_o;

  int n_pass  = 0;
  int n_total = 0;

  logic [3:0]  sel_v [3];
  logic [29:0] adr_v [3];
  logic [31:0] dat_v [3];

  wb_arbiter #(.NM(NM), .TMO_W(8)) dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_sel_i(m_sel_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
    .m_ack_o(m_ack_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .tmo_clr_i(tmo_clr_i), .tmo_o(tmo_o), .tmo_adr_o(tmo_adr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                       input logic [3:0] sel, input logic [29:0] adr, input logic [31:0] dat);
    m_cyc_i[k]          = cyc;
    m_stb_i[k]          = stb;
    m_we_i[k]           = we;
    m_sel_i[4*k +: 4]   = sel;
    m_adr_i[30*k +: 30] = adr;
    m_dat_i[32*k +: 32] = dat;
  endtask

  task automatic drop(input int k);
    set_m(k, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Entered at a negedge in BUSY owned by k: check mirror, ack one beat, release.
  task automatic serve(input int k, input logic [29:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we);
    #1;
    check($sformatf("own%0d_cyc", k), {31'h0, s_cyc_o}, 32'h1);
    check($sformatf("own%0d_adr", k), {2'b00, s_adr_o}, {2'b00, adr});
    check($sformatf("own%0d_dat", k), s_dat_o, dat);
    check($sformatf("own%0d_sel", k), {28'h0, s_sel_o}, {28'h0, sel});
    check($sformatf("own%0d_we", k), {31'h0, s_we_o}, {31'h0, we});
    s_ack_i = 1'b1;
    #1;
    check($sformatf("own%0d_ack", k), {29'h0, m_ack_o}, 32'h1 << k);
    step();
    s_ack_i = 1'b0;
    drop(k);
    #1;
    check($sformatf("own%0d_release", k), {31'h0, s_cyc_o}, 32'h0);
    step();
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    int stalls;
    int early;
    bit seen;

    sel_v = '{4'h1, 4'h3, 4'hC};
    adr_v = '{30'h10, 30'h20, 30'h30};
    dat_v = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222};
    rst = 1'b1;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_sel_i = '0; m_adr_i = '0; m_dat_i = '0;
    s_ack_i = 1'b0; s_dat_i = '0; tmo_clr_i = 1'b0;

    // Reset state
    step(); step();
    #1;
    check("rst_s_cyc", {31'h0, s_cyc_o}, 32'h0);
    check("rst_m_ack", {29'h0, m_ack_o}, 32'h0);
    check("rst_tmo", {31'h0, tmo_o}, 32'h0);
    check("rst_tmo_adr", {2'b00, tmo_adr_o}, 32'h0);
    check("rst_s_adr", {2'b00, s_adr_o}, 32'h0);
    rst = 1'b0;

    // Master 1 single read, slave acks two cycles after stb
    step();
    set_m(1, 1'b1, 1'b1, 1'b0, 4'hF, 30'h100, 32'h0);
    #1 check("t1_latency", {31'h0, s_cyc_o}, 32'h0);
    step();
    #1;
    check("t1_s_cyc", {31'h0, s_cyc_o}, 32'h1);
    check("t1_s_adr", {2'b00, s_adr_o}, 32'h100);
    check("t1_no_ack0", {29'h0, m_ack_o}, 32'h0);
    step();
    #1 check("t1_no_ack1", {29'h0, m_ack_o}, 32'h0);
    step();
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    #1;
    check("t1_ack", {29'h0, m_ack_o}, 32'h2);
    check("t1_rdata", m_dat_o, 32'hDEAD_BEEF);
    step();
    s_ack_i = 1'b0; s_dat_i = '0;
    drop(1);
    #1;
    check("t1_cyc_drop", {31'h0, s_cyc_o}, 32'h0);
    check("t1_ack_clear", {29'h0, m_ack_o}, 32'h0);

    // All three request together after reset: 0,1,2 then 0 again
    do_reset();
    for (int k = 0; k < 3; k++) set_m(k, 1'b1, 1'b1, 1'b1, sel_v[k], adr_v[k], dat_v[k]);
    step();
    serve(0, adr_v[0], dat_v[0], sel_v[0], 1'b1);
    step();
    serve(1, adr_v[1], dat_v[1], sel_v[1], 1'b1);
    step();
    serve(2, adr_v[2], dat_v[2], sel_v[2], 1'b1);
    set_m(0, 1'b1, 1'b1, 1'b1, 4'h7, 30'h11, 32'hB000_0000);
    set_m(1, 1'b1, 1'b1, 1'b1, 4'h8, 30'h21, 32'hB111_1111);
    step();
    serve(0, 30'h11, 32'hB000_0000, 4'h7, 1'b1);
    drop(1);

    // Master 0 holds cyc over 4 beats while master 2 waits
    set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 30'h40, 32'h0);
    step();
    set_m(2, 1'b1, 1'b1, 1'b0, 4'hF, 30'h50, 32'h0);
    for (int b = 0; b < 4; b++) begin
      m_stb_i[0] = 1'b1; s_ack_i = 1'b1; s_dat_i = 32'hC0 + b;
      #1;
      check($sformatf("t3_beat%0d_ack", b), {29'h0, m_ack_o}, 32'h1);
      check($sformatf("t3_beat%0d_data", b), m_dat_o, 32'hC0 + b);
      step();
      m_stb_i[0] = 1'b0; s_ack_i = 1'b0; s_dat_i = '0;
      #1;
      check($sformatf("t3_gap%0d_cyc", b), {31'h0, s_cyc_o}, 32'h1);
      check($sformatf("t3_gap%0d_adr", b), {2'b00, s_adr_o}, 32'h40);
      step();
    end
    drop(0);
    #1 check("t3_m0_release", {31'h0, s_cyc_o}, 32'h0);
    step();
    step();
    serve(2, 30'h50, 32'h0, 4'hF, 1'b0);

    // Hung slave on master 2 read: watchdog fires after 255 stalled cycles
    set_m(2, 1'b1, 1'b1, 1'b0, 4'hF, 30'h3FFFFFF, 32'h0);
    step();
    stalls = 0; seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      #1;
      if (m_ack_o[2]) seen = 1'b1;
      else begin
        if (s_stb_o) stalls++;
        step();
      end
    end
    check("t4_tmo_seen", {31'h0, seen}, 32'h1);
    check("t4_stalls", stalls, 32'd255);
    check("t4_ack", {29'h0, m_ack_o}, 32'h4);
    check("t4_rdata", m_dat_o, 32'hFFFF_FFFF);
    check("t4_s_stb", {31'h0, s_stb_o}, 32'h0);
    check("t4_s_cyc", {31'h0, s_cyc_o}, 32'h0);
    check("t4_tmo_flag", {31'h0, tmo_o}, 32'h1);
    check("t4_tmo_adr", {2'b00, tmo_adr_o}, 32'h3FFFFFF);
    step();
    drop(2);
    step();

    // Clear the flag, then ack in the final watchdog cycle
    tmo_clr_i = 1'b1;
    step();
    tmo_clr_i = 1'b0;
    #1 check("t5_clr", {31'h0, tmo_o}, 32'h0);
    set_m(2, 1'b1, 1'b1, 1'b0, 4'hF, 30'h20000, 32'h0);
    step();
    early = 0;
    for (int i = 0; i < 254; i++) begin
      #1;
      if (m_ack_o !== 3'b000) early++;
      step();
    end
    s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
    #1;
    check("t5_no_early_ack", early, 32'd0);
    check("t5_late_ack", {29'h0, m_ack_o}, 32'h4);
    check("t5_late_data", m_dat_o, 32'h1234_5678);
    step();
    s_ack_i = 1'b0; s_dat_i = '0;
    drop(2);
    #1 check("t5_no_tmo", {31'h0, tmo_o}, 32'h0);
    step();

    // Clear pulse coincides with a new timeout: set wins, address overwritten
    set_m(2, 1'b1, 1'b1, 1'b0, 4'hF, 30'h1555_5555, 32'h0);
    step();
    for (int i = 0; i < 254; i++) step();
    tmo_clr_i = 1'b1;
    step();
    tmo_clr_i = 1'b0;
    #1;
    check("t5b_tmo_ack", {29'h0, m_ack_o}, 32'h4);
    check("t5b_tmo_flag", {31'h0, tmo_o}, 32'h1);
    check("t5b_tmo_adr", {2'b00, tmo_adr_o}, 32'h1555_5555);
    step();
    drop(2);
    step();

    // Asynchronous reset mid-write
    set_m(0, 1'b1, 1'b1, 1'b1, 4'hF, 30'h60, 32'h66);
    step();
    serve(0, 30'h60, 32'h66, 4'hF, 1'b1);
    set_m(1, 1'b1, 1'b1, 1'b1, 4'h5, 30'h70, 32'h77);
    step();
    s_ack_i = 1'b1;
    #1;
    check("t6_pre_cyc", {31'h0, s_cyc_o}, 32'h1);
    check("t6_pre_ack", {29'h0, m_ack_o}, 32'h2);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_cyc", {31'h0, s_cyc_o}, 32'h0);
    check("t6_rst_ack", {29'h0, m_ack_o}, 32'h0);
    s_ack_i = 1'b0;
    step();
    set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 30'h80, 32'h0);
    rst = 1'b0;
    step();
    #1;
    check("t6_first_owner_adr", {2'b00, s_adr_o}, 32'h80);
    s_ack_i = 1'b1;
    #1 check("t6_first_owner_ack", {29'h0, m_ack_o}, 32'h1);
    step();
    s_ack_i = 1'b0;
    drop(0);
    drop(1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
